// File: rtl/prescaled_counter_pkg.sv
// Shared encodings for the prescaled up/down counter: terminal-count modes, FSM states, direction.
package prescaled_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RELOAD  = 2'b10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/prescale_tick_gen.sv
// Free-running prescaler: tick is high in the cycle the count reaches limit, period limit+1 cycles.
// Counts only while run is high; clear or !run force it back to zero.
module prescale_tick_gen #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] limit,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;

  // >= rather than == so a limit lowered below the current count still ticks.
  assign tick = run && (presc_q >= limit);

  always_comb begin
    presc_d = presc_q;
    if (clear || !run) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/prescaled_counter_ctrl.sv
// Up/down counter with prescaler, wrap/one-shot/reload terminal modes and compare match.
// Define SYNC_IN_EN to pass en/use_prescaler/dir/load/mode through 2-flop synchronisers (load edge-detected).
module prescaled_counter_ctrl
  import prescaled_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 24,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      use_prescaler,
  input  logic [PRESCALE_WIDTH-1:0] prescale_limit,
  input  logic                      dir,
  input  logic [1:0]                mode,
  input  logic                      load,
  input  logic [COUNTER_WIDTH-1:0]  load_val,
  input  logic [COUNTER_WIDTH-1:0]  cmp_val,
  output logic [COUNTER_WIDTH-1:0]  count,
  output logic                      tc_pulse,
  output logic                      match,
  output logic                      running,
  output logic                      done
);

  logic       en_e, use_e, dir_e, load_e;
  logic [1:0] mode_e;

`ifdef SYNC_IN_EN
  // Bit order: {mode[1:0], load, dir, use_prescaler, en}.
  logic [5:0] sync1_q, sync2_q;
  logic       load_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      load_prev_q <= 1'b0;
    end else begin
      sync1_q     <= {mode, load, dir, use_prescaler, en};
      sync2_q     <= sync1_q;
      load_prev_q <= sync2_q[3];
    end
  end

  assign en_e   = sync2_q[0];
  assign use_e  = sync2_q[1];
  assign dir_e  = sync2_q[2];
  assign load_e = sync2_q[3] & ~load_prev_q;
  assign mode_e = sync2_q[5:4];
`else
  assign en_e   = en;
  assign use_e  = use_prescaler;
  assign dir_e  = dir;
  assign load_e = load;
  assign mode_e = mode;
`endif

  state_e                     state_q;
  logic [COUNTER_WIDTH-1:0]   count_q, count_d;
  logic                       tc_q, tc_d;
  logic                       tick, step, term, run_ok;

  assign run_ok = (state_q == RUN) && en_e;

  prescale_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(load_e),
    .run  (run_ok),
    .limit(prescale_limit),
    .tick (tick)
  );

  assign step = run_ok && (use_e ? tick : 1'b1);
  assign term = (dir_e == DIR_DOWN) ? (count_q == '0) : (&count_q);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_e) begin
      count_d = load_val;
    end else if (step) begin
      if (dir_e == DIR_DOWN) count_d = count_q - COUNTER_WIDTH'(1);
      else                   count_d = count_q + COUNTER_WIDTH'(1);
      if (term) begin
        tc_d = 1'b1;
        if (mode_e == MODE_ONESHOT)     count_d = count_q;
        else if (mode_e == MODE_RELOAD) count_d = load_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      case (state_q)
        IDLE: if (en_e) state_q <= RUN;
        RUN: begin
          if (!en_e)                                       state_q <= IDLE;
          else if (tc_d && mode_e == MODE_ONESHOT)         state_q <= DONE;
        end
        DONE: begin
          if (!en_e)       state_q <= IDLE;
          else if (load_e) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count    = count_q;
  assign tc_pulse = tc_q;
  assign match    = (count_q == cmp_val);
  assign running  = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: doc/prescaled_counter_ctrl.md
Name: prescaled_counter_ctrl

Overview:
Parametrised up/down counter with a runtime-programmable prescaler, selectable terminal-count modes and a compare-match output, for user designs on the MPW5 fabric. It generalises the fixed-width, fixed-limit, free-running demo counter. All controls arrive from fabric IO pins or other user logic. Outputs feed pad drivers and debug observation.

Parameters:
COUNTER_WIDTH, 24, counter width in bits (>=2)
PRESCALE_WIDTH, 16, prescaler counter and limit width in bits (>=1)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable
use_prescaler  input  1  1: count on prescaler tick; 0: count on every clk
prescale_limit  input  PRESCALE_WIDTH  tick period is prescale_limit+1 cycles
dir  input  1  0: up, 1: down
mode  input  2  00 wrap, 01 one-shot, 10 reload, 11 treated as wrap
load  input  1  synchronous load strobe
load_val  input  COUNTER_WIDTH  load and reload value
cmp_val  input  COUNTER_WIDTH  compare value
count  output  COUNTER_WIDTH  current count
tc_pulse  output  1  one-cycle terminal-count pulse
match  output  1  high while count == cmp_val
running  output  1  high in RUN state
done  output  1  high in DONE state

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, prescaler=0, tc_pulse=0, running=0, done=0. match reflects count==cmp_val immediately.
- States:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - RUN -> DONE on a one-shot terminal event.
  - DONE -> IDLE when en=0.
  - DONE -> RUN on load while en=1.
  - IDLE loads stay in IDLE.
- Prescaler:
  - Increments only in RUN. Cleared to 0 in IDLE and DONE, and on load.
  - In RUN, tick=1 when prescaler >= prescale_limit; the prescaler then returns to 0 on the same edge.
  - The >= compare covers a limit lowered mid-count. limit=0 gives a tick every cycle.
- Count enable: step = RUN && (use_prescaler ? tick : 1).
  - With use_prescaler=1 and limit L, count steps once every L+1 cycles. The first step occurs L+1 cycles after entering RUN.
  - The prescaler free-runs in RUN regardless of use_prescaler.
- Terminal: up and count == all-ones, or down and count == 0, while step=1.
  - wrap: count wraps modulo 2^COUNTER_WIDTH.
  - one-shot: count holds the terminal value; next state DONE.
  - reload: count <= load_val.
  - tc_pulse=1 for exactly the cycle after the terminal edge (registered), in all modes.
- Non-terminal step: count +/- 1, modulo 2^COUNTER_WIDTH.
- Priority: rst > load > step.
  - load with step in the same cycle: count <= load_val, no step, no tc_pulse.
- en=0 mid-count: count holds, prescaler clears, no tc_pulse.
- dir or mode changes: take effect on the next step; no other side effect.
- match: combinational compare of the registered count against cmp_val; no added latency.
- running and done decode the state register directly.

Optional Feature:
SYNC_IN_EN:
- Defined: en, use_prescaler, dir, load and mode each pass through a 2-flop synchroniser, reset to 0. All control responses are delayed by 2 cycles. load is edge-detected after synchronisation, giving one load per rising edge.
- Undefined: inputs are used directly and load is level-sensitive (loads every cycle while high).
- prescale_limit, load_val and cmp_val are never synchronised; they must be quasi-static.

Decomposition:
- Shared package prescaled_counter_pkg holds:
  - mode encodings: MODE_WRAP=2'b00, MODE_ONESHOT=2'b01, MODE_RELOAD=2'b10
  - state encoding: IDLE, RUN, DONE
  - DIR_UP=0, DIR_DOWN=1
- One sub-module, prescale_tick_gen (parameter PRESCALE_WIDTH; ports clk, rst, clear, run, limit, tick), holds the prescaler logic. The top holds the FSM, count datapath and optional synchronisers.

Test Plan:
- Prescale period: COUNTER_WIDTH=8, use_prescaler=1, limit=10, en=1, up, wrap -> count 0->1 after 11 cycles, 5 after 55 cycles; limit=0 -> step every cycle.
- Wrap and underflow: load_val=8'hFE, load, up -> FE, FF, 00 with tc_pulse one cycle after the FF->00 edge; dir=1 from 01 -> 00, FF with a single tc_pulse.
- One-shot: load 8'hFD, mode=01, up, no prescale -> FD, FE, FF, then holds FF; done=1, running=0, one tc_pulse; load 8'h10 with en=1 -> RUN, counts from 10.
- Reload: load_val=8'h80, mode=10, up from FF -> next count 80, tc_pulse=1; load asserted on a terminal step -> load_val wins, no tc_pulse.
- Reset and enable mid-run: assert rst asynchronously mid-prescale -> count=0, state IDLE, all outputs 0 before the next edge; en=0 at count=5 -> holds 5, prescaler restarts full period on re-enable.
- Match and synchroniser: cmp_val=8'h07 -> match high only while count=07; with SYNC_IN_EN, rising en -> running=1 exactly 3 edges later, and a held load loads once.
